// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: redirect selects, NOP encoding, fetch FSM
// state encoding and small helpers used by the fetch stage.
package mips_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned PCSRC_W  = 2;
    localparam int unsigned PERF_W   = 32;
    localparam int unsigned JIDX_W   = 26;

    localparam logic [PCSRC_W-1:0] PCSRC_SEQ = 2'b00;
    localparam logic [PCSRC_W-1:0] PCSRC_BR  = 2'b01;
    localparam logic [PCSRC_W-1:0] PCSRC_JMP = 2'b10;

    localparam logic [INSTR_W-1:0] MIPS_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HELD  = 2'd2
    } fetch_state_e;

    // Instruction word captured while the pipeline is stalled
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [INSTR_W-1:0] pc4;
    } fetch_word_t;

    // Saturating increment for performance counters
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == {PERF_W{1'b1}}) ? v : v + PERF_W'(1);
    endfunction

endpackage

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats load beats bubble beats hold.
module if_id_reg
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic                load_i,
    input  logic                bubble_i,
    input  logic [INSTR_W-1:0]  instr_i,
    input  logic [ADDR_W-1:0]   pc4_i,
    output logic [INSTR_W-1:0]  instr_o,
    output logic [ADDR_W-1:0]   pc4_o,
    output logic                valid_o
);

    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  pc4_q;
    logic               valid_q;

    // pc4 is kept across a flush so a jump resolving in ID still sees it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= MIPS_NOP;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            instr_q <= MIPS_NOP;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
            valid_q <= 1'b1;
        end else if (bubble_i) begin
            valid_q <= 1'b0;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS instruction-fetch stage: PC, fetch FSM, stall holding buffer, IF/ID.
// Optional IF_PERF_CNT_EN adds saturating fetch/flush/stall counters.
module if_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PCSRC_W-1:0]  PCSrc,
    input  logic                ifflush,
    input  logic [ADDR_W-1:0]   branch_target,
    input  logic [JIDX_W-1:0]   jump_index,
    input  logic                stall,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                imem_ready,
    output logic [INSTR_W-1:0]  if_id_instr,
    output logic [ADDR_W-1:0]   if_id_pc4,
    output logic                if_id_valid,
    output logic [PERF_W-1:0]   perf_fetch,
    output logic [PERF_W-1:0]   perf_flush,
    output logic [PERF_W-1:0]   perf_stall
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] buf_instr_q, buf_instr_d;
    logic [ADDR_W-1:0]  buf_pc4_q, buf_pc4_d;
    logic               req_q;

    logic [ADDR_W-1:0]  pc_plus4;
    logic [ADDR_W-1:0]  jump_target;
    logic               ifid_load;
    logic               ifid_flush;
    logic               ifid_bubble;
    logic [INSTR_W-1:0] ifid_instr_in;
    logic [ADDR_W-1:0]  ifid_pc4_in;

    assign pc_plus4    = pc_q + ADDR_W'(4);
    assign jump_target = ADDR_W'({if_id_pc4[ADDR_W-1 -: 4], jump_index, 2'b00});

    // State, PC, holding buffer and the registered fetch request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_BOOT;
            pc_q        <= ADDR_W'(RESET_PC);
            buf_instr_q <= MIPS_NOP;
            buf_pc4_q   <= '0;
            req_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_instr_q <= buf_instr_d;
            buf_pc4_q   <= buf_pc4_d;
            req_q       <= (state_d == S_FETCH);
        end
    end

    // Next-state logic; a redirect overrides stall, memory response and state
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        buf_instr_d   = buf_instr_q;
        buf_pc4_d     = buf_pc4_q;
        ifid_load     = 1'b0;
        ifid_flush    = 1'b0;
        ifid_bubble   = 1'b0;
        ifid_instr_in = imem_rdata;
        ifid_pc4_in   = pc_plus4;

        if (ifflush) begin
            ifid_flush  = 1'b1;
            state_d     = S_FETCH;
            buf_instr_d = MIPS_NOP;
            buf_pc4_d   = '0;
            case (PCSrc)
                PCSRC_BR:  pc_d = branch_target;
                PCSRC_JMP: pc_d = jump_target;
                default:   pc_d = pc_q;
            endcase
        end else begin
            case (state_q)
                S_BOOT: begin
                    state_d = S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        if (!stall) begin
                            ifid_load = 1'b1;
                            pc_d      = pc_plus4;
                        end else begin
                            buf_instr_d = imem_rdata;
                            buf_pc4_d   = pc_plus4;
                            state_d     = S_HELD;
                        end
                    end else if (!stall) begin
                        ifid_bubble = 1'b1;
                    end
                end
                S_HELD: begin
                    if (!stall) begin
                        ifid_load     = 1'b1;
                        ifid_instr_in = buf_instr_q;
                        ifid_pc4_in   = buf_pc4_q;
                        pc_d          = pc_plus4;
                        state_d       = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_BOOT;
                end
            endcase
        end
    end

    if_id_reg #(
        .ADDR_W (ADDR_W)
    ) u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (ifid_flush),
        .load_i   (ifid_load),
        .bubble_i (ifid_bubble),
        .instr_i  (ifid_instr_in),
        .pc4_i    (ifid_pc4_in),
        .instr_o  (if_id_instr),
        .pc4_o    (if_id_pc4),
        .valid_o  (if_id_valid)
    );

    assign imem_req  = req_q;
    assign imem_addr = pc_q;

`ifdef IF_PERF_CNT_EN
    logic [PERF_W-1:0] perf_fetch_q;
    logic [PERF_W-1:0] perf_flush_q;
    logic [PERF_W-1:0] perf_stall_q;

    // A stall cycle is only counted when it is not overridden by a redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (ifid_load)
                perf_fetch_q <= sat_inc(perf_fetch_q);
            if (ifflush)
                perf_flush_q <= sat_inc(perf_flush_q);
            if (stall && !ifflush)
                perf_stall_q <= sat_inc(perf_stall_q);
        end
    end

    assign perf_fetch = perf_fetch_q;
    assign perf_flush = perf_flush_q;
    assign perf_stall = perf_stall_q;
`else
    assign perf_fetch = '0;
    assign perf_flush = '0;
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the fetch stage.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  PCSrc;
    logic        ifflush;
    logic [31:0] branch_target;
    logic [25:0] jump_index;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [31:0] perf_fetch, perf_flush, perf_stall;

    int n_tests = 0;
    int n_fail  = 0;

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .ifflush(ifflush),
        .branch_target(branch_target), .jump_index(jump_index), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ready(imem_ready), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid), .perf_fetch(perf_fetch), .perf_flush(perf_flush),
        .perf_stall(perf_stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    function automatic logic [31:0] exp_perf(input logic [31:0] v);
`ifdef IF_PERF_CNT_EN
        return v;
`else
        return (v & 32'h0);
`endif
    endfunction

    // Behavioural model: fetching unless just out of reset or holding a word
    logic [31:0] m_pc, m_bi, m_bp4, m_ii, m_ip4;
    logic        m_boot, m_held, m_iv;
    int          m_pf, m_pfl, m_ps;

    task automatic model_reset();
        m_pc = 32'h0; m_boot = 1'b1; m_held = 1'b0;
        m_bi = 32'h0; m_bp4 = 32'h0;
        m_iv = 1'b0; m_ii = 32'h0; m_ip4 = 32'h0;
        m_pf = 0; m_pfl = 0; m_ps = 0;
    endtask

    task automatic model_step();
        if (stall && !ifflush) m_ps++;
        if (ifflush) begin
            m_pfl++;
            m_iv = 1'b0; m_ii = 32'h0;
            m_held = 1'b0; m_boot = 1'b0;
            if (PCSrc == 2'b01)      m_pc = branch_target;
            else if (PCSrc == 2'b10) m_pc = {m_ip4[31:28], jump_index, 2'b00};
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_held) begin
            if (!stall) begin
                m_ii = m_bi; m_ip4 = m_bp4; m_iv = 1'b1;
                m_pc = m_pc + 32'd4; m_held = 1'b0; m_pf++;
            end
        end else if (imem_ready) begin
            if (!stall) begin
                m_ii = mem_word(m_pc); m_ip4 = m_pc + 32'd4; m_iv = 1'b1;
                m_pc = m_pc + 32'd4; m_pf++;
            end else begin
                m_bi = mem_word(m_pc); m_bp4 = m_pc + 32'd4; m_held = 1'b1;
            end
        end else if (!stall) begin
            m_iv = 1'b0;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        PCSrc = 2'b00; ifflush = 1'b0; branch_target = 32'h0;
        jump_index = 26'h0; stall = 1'b0; imem_ready = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        ifflush = 1'b1; PCSrc = 2'b01; branch_target = tgt;
        cycle();
        ifflush = 1'b0; PCSrc = 2'b00;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_tests++;
        if (imem_addr !== 32'h0 || imem_req !== 1'b0 || if_id_valid !== 1'b0 ||
            if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: addr=%h req=%b valid=%b instr=%h pc4=%h required 0", imem_addr, imem_req, if_id_valid, if_id_instr, if_id_pc4);
        end
        n_tests++;
        if (perf_fetch !== 32'h0 || perf_flush !== 32'h0 || perf_stall !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_perf: %h %h %h required 0", perf_fetch, perf_flush, perf_stall);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        imem_ready = 1'b1;
        cycle();
        n_tests++;
        if (imem_addr !== 32'h0 || imem_req !== 1'b1 || if_id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL boot_exit: addr=%h req=%b valid=%b required 0/1/0", imem_addr, imem_req, if_id_valid);
        end
        for (int i = 1; i <= 4; i++) begin
            cycle();
            n_tests++;
            if (if_id_valid !== 1'b1 || if_id_pc4 !== 32'(4 * i) ||
                if_id_instr !== mem_word(32'(4 * (i - 1))) || imem_addr !== 32'(4 * i)) begin
                n_fail++;
                $display("FAIL seq_fetch%0d: valid=%b pc4=%h instr=%h addr=%h required 1/%h/%h/%h", i, if_id_valid, if_id_pc4, if_id_instr, imem_addr, 32'(4 * i), mem_word(32'(4 * (i - 1))), 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall_hold();
        redirect(32'h10);
        imem_ready = 1'b1; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_tests++;
            if (imem_req !== 1'b0 || imem_addr !== 32'h10 || if_id_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: req=%b addr=%h valid=%b required 0/10/0", i, imem_req, imem_addr, if_id_valid);
            end
        end
        stall = 1'b0;
        cycle();
        n_tests++;
        if (if_id_valid !== 1'b1 || if_id_pc4 !== 32'h14 || if_id_instr !== mem_word(32'h10) ||
            imem_addr !== 32'h14 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: valid=%b pc4=%h instr=%h addr=%h req=%b required 1/14/%h/14/1", if_id_valid, if_id_pc4, if_id_instr, imem_addr, imem_req, mem_word(32'h10));
        end
        cycle();
        n_tests++;
        if (if_id_pc4 !== 32'h18 || if_id_instr !== mem_word(32'h14)) begin
            n_fail++;
            $display("FAIL stall_next: pc4=%h instr=%h required 18/%h", if_id_pc4, if_id_instr, mem_word(32'h14));
        end
    endtask

    task automatic test_flush_branch();
        imem_ready = 1'b1; stall = 1'b1;
        ifflush = 1'b1; PCSrc = 2'b01; branch_target = 32'h100;
        cycle();
        n_tests++;
        if (imem_addr !== 32'h100 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_branch: addr=%h valid=%b instr=%h req=%b required 100/0/0/1", imem_addr, if_id_valid, if_id_instr, imem_req);
        end
        ifflush = 1'b0; PCSrc = 2'b00; stall = 1'b0;
    endtask

    task automatic test_jump();
        redirect(32'h4000_0004);
        imem_ready = 1'b1;
        cycle();
        ifflush = 1'b1; PCSrc = 2'b10; jump_index = 26'h0000040;
        cycle();
        n_tests++;
        if (imem_addr !== 32'h4000_0100 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
            n_fail++;
            $display("FAIL jump: addr=%h valid=%b instr=%h required 40000100/0/0", imem_addr, if_id_valid, if_id_instr);
        end
        ifflush = 1'b0; PCSrc = 2'b00;
    endtask

    task automatic test_ready_low();
        redirect(32'h20);
        imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_tests++;
            if (if_id_valid !== 1'b0 || imem_addr !== 32'h20) begin
                n_fail++;
                $display("FAIL not_ready%0d: valid=%b addr=%h required 0/20", i, if_id_valid, imem_addr);
            end
        end
        imem_ready = 1'b1;
        cycle();
        n_tests++;
        if (if_id_valid !== 1'b1 || if_id_instr !== mem_word(32'h20) || if_id_pc4 !== 32'h24) begin
            n_fail++;
            $display("FAIL ready_capture: valid=%b instr=%h pc4=%h required 1/%h/24", if_id_valid, if_id_instr, if_id_pc4, mem_word(32'h20));
        end
        redirect(32'hFFFF_FFFC);
        cycle();
        n_tests++;
        if (imem_addr !== 32'h0 || if_id_pc4 !== 32'h0 || if_id_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pc_wrap: addr=%h pc4=%h valid=%b required 0/0/1", imem_addr, if_id_pc4, if_id_valid);
        end
    endtask

    task automatic test_unused_pcsrc();
        imem_ready = 1'b1;
        cycle();
        ifflush = 1'b1; imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            PCSrc = (i == 0) ? 2'b00 : 2'b11;
            branch_target = 32'h800;
            cycle();
            n_tests++;
            if (imem_addr !== 32'h4 || if_id_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_only_pcsrc%0d: addr=%h valid=%b required 4/0", i, imem_addr, if_id_valid);
            end
        end
        ifflush = 1'b0; PCSrc = 2'b00;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            ifflush       = ($urandom_range(0, 9) == 0);
            PCSrc         = 2'($urandom_range(0, 3));
            branch_target = $urandom & 32'hFFFF_FFFC;
            jump_index    = 26'($urandom);
            stall         = ($urandom_range(0, 3) == 0);
            imem_ready    = ($urandom_range(0, 3) != 0);
            cycle();
            n_tests++;
            if (imem_addr !== m_pc || imem_req !== (!m_boot && !m_held) || if_id_valid !== m_iv ||
                (m_iv && (if_id_instr !== m_ii || if_id_pc4 !== m_ip4))) begin
                n_fail++;
                $display("FAIL random_c%0d: addr=%h req=%b valid=%b instr=%h pc4=%h required %h/%b/%b/%h/%h", c, imem_addr, imem_req, if_id_valid, if_id_instr, if_id_pc4, m_pc, !m_boot && !m_held, m_iv, m_ii, m_ip4);
            end
            n_tests++;
            if (perf_fetch !== exp_perf(32'(m_pf)) || perf_flush !== exp_perf(32'(m_pfl)) ||
                perf_stall !== exp_perf(32'(m_ps))) begin
                n_fail++;
                $display("FAIL random_perf_c%0d: %0d %0d %0d required %0d %0d %0d", c, perf_fetch, perf_flush, perf_stall, exp_perf(32'(m_pf)), exp_perf(32'(m_pfl)), exp_perf(32'(m_ps)));
            end
            if (c == 200) begin
                rst_n = 1'b0;
                #2;
                model_reset();
                n_tests++;
                if (imem_addr !== 32'h0 || imem_req !== 1'b0 || if_id_valid !== 1'b0 ||
                    if_id_instr !== 32'h0 || perf_fetch !== 32'h0) begin
                    n_fail++;
                    $display("FAIL mid_reset: addr=%h req=%b valid=%b instr=%h pf=%0d required 0", imem_addr, imem_req, if_id_valid, if_id_instr, perf_fetch);
                end
                rst_n = 1'b1;
            end
        end
    endtask

    task automatic test_perf();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        imem_ready = 1'b1;
        repeat (6) cycle();
        imem_ready = 1'b0; ifflush = 1'b1;
        repeat (2) cycle();
        ifflush = 1'b0; stall = 1'b1;
        repeat (3) cycle();
        stall = 1'b0;
        n_tests++;
        if (perf_fetch !== exp_perf(32'd5) || perf_flush !== exp_perf(32'd2) ||
            perf_stall !== exp_perf(32'd3)) begin
            n_fail++;
            $display("FAIL perf_counts: %0d %0d %0d required %0d %0d %0d", perf_fetch, perf_flush, perf_stall, exp_perf(32'd5), exp_perf(32'd2), exp_perf(32'd3));
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_hold();
        test_flush_branch();
        test_jump();
        test_ready_low();
        test_unused_pcsrc();
        test_random();
        test_perf();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the PC and the IF/ID pipeline register.
- It consumes the redirect controls (PCSrc, ifflush, branch/jump targets) that the ID-stage controller produces, drives the instruction-memory request, and absorbs hazard-unit stalls and multi-cycle memory latency through a small FSM and a one-entry holding buffer.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC / address width (instruction width fixed at 32).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- PCSrc  in  2  redirect select from controller: 00 sequential, 01 branch, 10 jump
- ifflush  in  1  redirect strobe from controller; flush IF/ID
- branch_target  in  ADDR_W  branch target computed in ID
- jump_index  in  26  instr[25:0] of the jump in ID
- stall  in  1  hazard unit: hold PC and IF/ID
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address (= pc)
- imem_rdata  in  32  instruction word, valid when imem_ready
- imem_ready  in  1  memory returns data for current imem_addr this cycle
- if_id_instr  out  32  IF/ID instruction
- if_id_pc4  out  ADDR_W  IF/ID PC+4
- if_id_valid  out  1  IF/ID holds a real instruction
- perf_fetch, perf_flush, perf_stall  out  32 each  performance counters

Behaviour:
- Reset values (async on rst_n low):
  - pc=RESET_PC; state=S_BOOT.
  - if_id_instr=32'h0000_0000 (NOP); if_id_pc4=0; if_id_valid=0.
  - Holding buffer empty; imem_req=0; all perf counters 0.
- imem_addr = pc at all times. imem_req = 1 only in S_FETCH.
- Memory protocol:
  - No outstanding transactions. imem_ready is meaningful only while imem_req=1, and refers to the current imem_addr.
  - The address may change, or req may drop, without ack. Memory must tolerate this.
- next_pc:
  - Sequential: pc+4, modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0.
  - Branch: branch_target.
  - Jump: {if_id_pc4[31:28], jump_index, 2'b00}.
- FSM states and transitions:
  - S_BOOT: one idle cycle after reset release → S_FETCH.
  - S_FETCH, imem_ready=1 & stall=0: IF/ID <= {imem_rdata, pc+4, valid=1}; pc <= pc+4; stay.
  - S_FETCH, imem_ready=1 & stall=1: buffer <= {imem_rdata, pc+4}; IF/ID unchanged; pc unchanged → S_HELD.
  - S_FETCH, imem_ready=0: IF/ID valid <= 0 only if stall=0 (bubble); else hold; pc unchanged.
  - S_HELD: imem_req=0. When stall=0: IF/ID <= buffer with valid=1; pc <= pc+4 → S_FETCH.
- Redirect (ifflush=1) has highest priority, above stall, imem_ready and any state:
  - if_id_valid<=0 and if_id_instr<=NOP.
  - Buffer discarded; any in-flight response is ignored that cycle.
  - pc <= branch_target (PCSrc=01) or jump target (PCSrc=10) → S_FETCH.
- Illegal/unused combinations:
  - ifflush=1 with PCSrc=00 or 11: flush only, pc unchanged (current pc refetched).
  - ifflush=0: PCSrc ignored, sequential flow.
- Redirect during S_BOOT: pc loaded, state → S_FETCH.
- Reset mid-fetch: everything returns to reset values immediately; no partial IF/ID update.
- Throughput: one instruction per cycle when imem_ready is held 1 and no stall. Fetch-to-IF/ID latency is 1 clock edge.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined — three 32-bit saturating counters:
  - perf_fetch: +1 per instruction written to IF/ID with valid=1.
  - perf_flush: +1 per cycle with ifflush=1.
  - perf_stall: +1 per cycle with stall=1 and ifflush=0.
- Undefined: the perf_* ports exist but are tied to 0, and no counter flops are synthesized.

Decomposition:
- Shared package/include mips_pkg holds:
  - PCSRC_SEQ=2'b00, PCSRC_BR=2'b01, PCSRC_JMP=2'b10.
  - MIPS_NOP=32'h0.
  - Fetch FSM encoding: S_BOOT, S_FETCH, S_HELD.
- Sub-module if_id_reg: the IF/ID register with load/flush/hold controls, reused by the datapath top.

Test Plan:
1. Reset release with RESET_PC=0, imem_ready=1 constantly, no stall/flush → imem_addr 0,4,8,…; S_BOOT lasts 1 cycle; IF/ID pc4 4,8,12 on consecutive cycles; valid=1 from the 2nd cycle after release.
2. Stall asserted 3 cycles while the fetch at pc=0x10 returns → instruction buffered, imem_req=0, IF/ID unchanged. Stall drop → IF/ID gets buffered instr with pc4=0x14; next fetch at 0x14; no instruction lost or duplicated.
3. ifflush=1, PCSrc=01, branch_target=0x100, simultaneous with stall=1 → next cycle pc=0x100, if_id_valid=0, state S_FETCH.
4. ifflush=1, PCSrc=10, if_id_pc4=0x4000_0008, jump_index=26'h0000040 → pc=0x4000_0100; IF/ID flushed.
5. imem_ready=0 for 2 cycles at pc=0x20 → two bubbles (valid=0), pc held. Ready → instr at 0x20 captured. Wrap check: pc=0xFFFF_FFFC sequential → pc=0.
6. IF_PERF_CNT_EN defined: 5 fetches, 2 flush cycles, 3 stall cycles → perf_fetch=5, perf_flush=2, perf_stall=3. Undefined → all 0.
